// File: rtl/kalu_pkg.sv
// kalu_pkg: opcodes, FSM encoding and constants shared by the sequential ALU
package kalu_pkg;
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_SUB4 = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [7:0] SUB4_K  = 8'hFB;
    localparam int         N_ITER  = 8;
    typedef enum logic [1:0] {IDLE, EXEC, ITER, DONE} state_t;
endpackage

// File: rtl/kalu_seq_ctrl_if.sv
// kalu_seq_ctrl_if: request/result bundle between a client and the sequential ALU
interface kalu_seq_ctrl_if #(parameter int W = 8);
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         carry;
    logic         zero;
    logic         err;
    modport master (output start, op, a, b, input ready, busy, done, result, result_hi, carry, zero, err);
    modport slave (input start, op, a, b, output ready, busy, done, result, result_hi, carry, zero, err);
endinterface

// File: rtl/kalu_seq_ctrl_add_sub_8.sv
// add_sub_8: ripple-carry adder x + y + cin, the only arithmetic in the ALU
module add_sub_8 #(parameter int W = 8) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);
    logic [W:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < W; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    assign cout = c[W];
endmodule

// File: rtl/kalu_seq_ctrl.sv
// kalu_seq_ctrl: multi-cycle ALU sequencer sharing one adder across add/sub/mul/div
import kalu_pkg::*;
module kalu_seq_ctrl #(parameter int W = 8) (
    input logic             clk,
    input logic             rst,
    kalu_seq_ctrl_if.slave  bus_io
);
    state_t       state_q;
    logic [2:0]   cnt_q, op_q;
    logic [W-1:0] opa_q, opb_q, acc_q, lo_q, result_q, result_hi_q;
    logic         carry_q, zero_q, err_q, done_q;
    logic [W-1:0] x, y, s, acc_d, lo_d;
    logic         cin, cout, is_div, div_ok;
    add_sub_8 #(.W(W)) u_add (.x(x), .y(y), .cin(cin), .s(s), .cout(cout));
    // Adder operand steering: EXEC does add/sub, ITER does shift-add or trial subtract
    always_comb begin
        is_div = op_q == OP_DIV;
        x      = state_q != ITER ? opa_q : is_div ? {acc_q[W-2:0], lo_q[W-1]} : acc_q;
        y      = state_q == ITER ? (is_div ? ~opb_q : (lo_q[0] ? opa_q : '0))
               : op_q == OP_ADD ? opb_q : op_q == OP_SUB ? ~opb_q : W'(SUB4_K);
        cin    = state_q == ITER ? is_div : op_q != OP_ADD;
    end
    // Next partial product / remainder; the shifted-out MSB makes the trial subtract succeed too
    always_comb begin
        div_ok = acc_q[W-1] | cout;
        acc_d  = is_div ? (div_ok ? s : x) : {cout, s[W-1:1]};
        lo_d   = is_div ? {lo_q[W-2:0], div_ok} : {s[0], lo_q[W-1:1]};
    end
    // Sequencer: accept, execute or iterate, then publish results on entry to DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            acc_q       <= '0;
            lo_q        <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus_io.start) begin
                    op_q  <= bus_io.op;
                    opa_q <= bus_io.a;
                    opb_q <= bus_io.b;
                    cnt_q <= '0;
                    acc_q <= '0;
                    if (bus_io.op inside {OP_ADD, OP_SUB, OP_SUB4}) begin
                        state_q <= EXEC;
                    end else if (bus_io.op == OP_MUL || (bus_io.op == OP_DIV && bus_io.b != '0)) begin
                        lo_q    <= bus_io.op == OP_MUL ? bus_io.b : bus_io.a;
                        state_q <= ITER;
                    end else begin
                        result_q    <= bus_io.op == OP_DIV ? '1 : '0;
                        result_hi_q <= bus_io.op == OP_DIV ? bus_io.a : '0;
                        carry_q     <= 1'b0;
                        zero_q      <= 1'b0;
                        err_q       <= 1'b1;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                EXEC: begin
                    result_q    <= s;
                    result_hi_q <= '0;
                    carry_q     <= cout;
                    zero_q      <= s == '0;
                    err_q       <= 1'b0;
                    done_q      <= 1'b1;
                    state_q     <= DONE;
                end
                ITER: begin
                    acc_q <= acc_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'(N_ITER - 1)) begin
                        result_q    <= lo_d;
                        result_hi_q <= acc_d;
                        carry_q     <= !is_div && acc_d != '0;
                        zero_q      <= lo_d == '0;
                        err_q       <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
    assign bus_io.ready     = state_q == IDLE;
    assign bus_io.busy      = state_q != IDLE;
    assign bus_io.done      = done_q;
    assign bus_io.result    = result_q;
    assign bus_io.result_hi = result_hi_q;
    assign bus_io.carry     = carry_q;
    assign bus_io.zero      = zero_q;
    assign bus_io.err       = err_q;
endmodule

// File: doc/kalu_seq_ctrl.md
KALU_SEQ_CTRL -- requirements
Module: kalu_seq_ctrl

Interface
REQ-001 The interface SHALL have one clock, clk, and its reset, rst, SHALL be asynchronous and active-high.
REQ-002 Parameter W, default 8: datapath width; all operand and result widths below are W.
REQ-003 clk  in  1: rising-edge clock for all state.
REQ-004 rst  in  1: asynchronous, active-high reset.
REQ-005 start  in  1: operation request, sampled only while ready=1.
REQ-006 op  in  3: opcode. 000 ADD, 001 SUB, 010 SUB4, 011 MUL, 100 DIV; 101-111 are illegal.
REQ-007 a, b  in  W: operands, captured on the accept edge.
REQ-008 ready  out  1: high only in IDLE.
REQ-009 busy  out  1: inverse of ready.
REQ-010 done  out  1: one-cycle completion pulse.
REQ-011 result  out  W: sum, difference, product low half or quotient.
REQ-012 result_hi  out  W: product high half or remainder; 0 for ADD, SUB and SUB4.
REQ-013 carry, zero, err  out  1 each: status flags, valid while done=1 and held afterwards.

Function
REQ-014 The state machine SHALL have the states IDLE, EXEC, ITER and DONE.
REQ-015 Transitions SHALL be:
- IDLE -> EXEC on accept of ADD, SUB or SUB4.
- IDLE -> ITER on accept of MUL, or of DIV with b!=0.
- EXEC -> DONE.
- ITER -> DONE after the 8th iteration.
- DONE -> IDLE.
REQ-016 An accept SHALL be start=1 while in IDLE; start in any other state SHALL be ignored, and the operands are not re-sampled.
REQ-017 All arithmetic SHALL use one shared add_sub_8 instance (x + y + cin):
- ADD: a+b, cin=0.
- SUB: a+~b, cin=1.
- SUB4: a+8'hFB, cin=1.
REQ-018 ADD: carry = adder carry-out.
REQ-019 SUB and SUB4: carry=1 SHALL mean no borrow (a>=subtrahend); results wrap modulo 256.
REQ-020 MUL SHALL be unsigned shift-add over 8 ITER cycles, using the adder once per cycle.
- {result_hi,result} = a*b.
- carry = (result_hi!=0).
REQ-021 DIV SHALL be unsigned restoring division over 8 ITER cycles, using the adder as trial subtractor once per cycle.
- result = a/b, result_hi = a%b.
- carry = 0.
REQ-022 zero SHALL be (result==0) for every legal operation.
REQ-023 Latency from accept edge to the edge on which done rises SHALL be 2 cycles for ADD/SUB/SUB4 and 9 cycles for MUL/DIV; done SHALL be high for exactly one cycle.
REQ-024 DIV with b==0 SHALL go IDLE -> DONE directly (done one edge after accept) with err=1, result=8'hFF, result_hi=a, carry=0, zero=0.
REQ-025 An illegal opcode SHALL go IDLE -> DONE directly with err=1, result=0, result_hi=0, carry=0, zero=0.
REQ-026 err SHALL be 0 for all legal, non-divide-by-zero operations.
REQ-027 result, result_hi, carry, zero and err SHALL hold their values until the next accept; a new accept SHALL leave them unchanged until its own DONE.
REQ-028 start held high through DONE SHALL be accepted again on the first IDLE cycle, giving back-to-back operations with one idle cycle between them.

Reset
REQ-029 Asserting rst SHALL force, without waiting for a clock edge:
- state=IDLE, ready=1, busy=0, done=0.
- result=0, result_hi=0, carry=0, zero=0, err=0.
- iteration counter and internal operand registers = 0.
REQ-030 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first accept after release SHALL behave as it does from a fresh reset.

Structure
REQ-031 Package kalu_pkg SHALL hold the opcode constants, the state encoding, the SUB4 constant 8'hFB and the iteration count 8.
REQ-032 Sub-module add_sub_8 SHALL contain only the ripple adder (inputs x, y, cin; outputs s, cout) and SHALL be the only arithmetic in the block.
REQ-033 The iteration counter SHALL be 3 bits.

Verification
REQ-034 ADD a=200, b=100 -> result=44, carry=1, zero=0, done 2 cycles after accept.
REQ-035 SUB4 a=3 -> result=255, carry=0; then SUB4 a=4 -> result=0, zero=1, carry=1.
REQ-036 MUL a=255, b=255 -> result_hi=8'hFE, result=8'h01, carry=1, done 9 cycles after accept; busy=1 throughout.
REQ-037 DIV a=200, b=7 -> result=28, result_hi=4, err=0; then DIV a=9, b=0 -> err=1, result=8'hFF, result_hi=9, done 1 cycle after accept.
REQ-038 Start MUL, toggle start and the operands during ITER, assert rst at iteration 4 -> no done, all outputs 0; a subsequent ADD 1+1 -> result=2.
REQ-039 op=3'b110 -> err=1, result=0, done 1 cycle after accept; start held high continuously -> one accept per DONE->IDLE pass.
